// File: rtl/coeff_ram_arbiter.sv
// Shares the single-port coefficient RAM between the VME coefficient loader
// and the fit engine; decodes VME command words and returns readback data.
module coeff_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [33:0]       vme_bus_in,
  input  logic              vme_wrpulse,
  input  logic              vme_rdpulse,
  output logic              vme_dv,
  output logic [33:0]       vme_rdata,
  input  logic              fit_req,
  input  logic [ADDR_W-1:0] fit_addr,
  output logic              fit_gnt,
  output logic              fit_dv,
  output logic [DATA_W-1:0] fit_rdata,
  output logic              hold,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cmd_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RDWAIT, RDHOLD} state_t;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_SETA  = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_END   = 2'b11;

  state_t              state_q, state_d;
  logic [33:0]         pend_q;
  logic                pend_vld_q;
  logic                consume;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                hold_q;
  logic                err_q, err_d;
  logic                vme_dv_q, vme_dv_d;
  logic [33:0]         vme_rdata_q, vme_rdata_d;
  logic                fit_vld_p1_q;
  logic                fit_dv_q;
  logic [DATA_W-1:0]   fit_rdata_q;

  logic [1:0]          pend_cmd;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;

  assign pend_cmd  = pend_q[33:32];
  assign pend_addr = pend_q[14 +: ADDR_W];
  assign pend_data = pend_q[DATA_W-1:0];

  function automatic logic [33:0] pack_readback(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
    logic [33:0] w;
    w              = '0;
    w[33:32]       = CMD_READ;
    w[14 +: ADDR_W] = a;
    w[DATA_W-1:0]  = d;
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    consume     = 1'b0;
    err_d       = err_q;
    vme_dv_d    = vme_dv_q;
    vme_rdata_d = vme_rdata_q;
    fit_gnt     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = ptr_q;
    ram_wdata   = pend_data;
    case (state_q)
      IDLE: begin
        // Fit engine always wins in IDLE; a pending command waits for a free cycle.
        if (fit_req) begin
          fit_gnt  = 1'b1;
          ram_en   = 1'b1;
          ram_addr = fit_addr;
        end else if (pend_vld_q) begin
          consume = 1'b1;
          if (pend_cmd == CMD_SETA) begin
            ptr_d   = pend_addr;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pend_vld_q) begin
          consume = 1'b1;
          case (pend_cmd)
            CMD_WRITE: begin
              ram_en = 1'b1;
              ram_we = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end
            CMD_SETA: ptr_d = pend_addr;
            CMD_READ: begin
              ram_en  = 1'b1;
              state_d = RDWAIT;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RDWAIT: begin
        vme_rdata_d = pack_readback(ptr_q, ram_rdata);
        vme_dv_d    = 1'b1;
        ptr_d       = ptr_q + 1'b1;
        state_d     = RDHOLD;
      end
      default: begin
        if (vme_rdpulse) begin
          vme_dv_d = 1'b0;
          state_d  = LOAD;
        end
      end
    endcase
    if (vme_wrpulse && pend_vld_q && !consume) err_d = 1'b1;
    // Keep the RAM and grant quiet while reset is asserted.
    if (!reset) begin
      fit_gnt = 1'b0;
      ram_en  = 1'b0;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      ptr_q        <= '0;
      hold_q       <= 1'b0;
      err_q        <= 1'b0;
      vme_dv_q     <= 1'b0;
      vme_rdata_q  <= '0;
      fit_vld_p1_q <= 1'b0;
      fit_dv_q     <= 1'b0;
      fit_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= (state_d != IDLE);
      err_q       <= err_d;
      vme_dv_q    <= vme_dv_d;
      vme_rdata_q <= vme_rdata_d;
      if (vme_wrpulse && (!pend_vld_q || consume)) begin
        pend_q     <= vme_bus_in;
        pend_vld_q <= 1'b1;
      end else if (consume) begin
        pend_vld_q <= 1'b0;
      end
      // fit read pipeline: grant -> RAM data -> registered output
      fit_vld_p1_q <= fit_gnt;
      fit_dv_q     <= fit_vld_p1_q;
      if (fit_vld_p1_q) fit_rdata_q <= ram_rdata;
    end
  end

  assign hold      = hold_q;
  assign cmd_err   = err_q;
  assign vme_dv    = vme_dv_q;
  assign vme_rdata = vme_rdata_q;
  assign fit_dv    = fit_dv_q;
  assign fit_rdata = fit_rdata_q;

endmodule

// File: tb/tb_coeff_ram_arbiter.sv
// Scoreboard bench for coeff_ram_arbiter with a behavioural single-port RAM.
module tb_coeff_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] vme_bus_in;
  logic        vme_wrpulse, vme_rdpulse;
  logic        vme_dv;
  logic [33:0] vme_rdata;
  logic        fit_req;
  logic [9:0]  fit_addr;
  logic        fit_gnt, fit_dv;
  logic [13:0] fit_rdata;
  logic        hold, ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [13:0] ram_wdata;
  logic [13:0] ram_rdata;
  logic        cmd_err;

  logic [13:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [13:0] bd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [13:0] exp_q[$];
  int          gcyc_q[$];

  always #5 clk = ~clk;

  coeff_ram_arbiter #(.ADDR_W(10), .DATA_W(14)) dut (
    .clk(clk), .reset(reset), .vme_bus_in(vme_bus_in),
    .vme_wrpulse(vme_wrpulse), .vme_rdpulse(vme_rdpulse),
    .vme_dv(vme_dv), .vme_rdata(vme_rdata),
    .fit_req(fit_req), .fit_addr(fit_addr), .fit_gnt(fit_gnt),
    .fit_dv(fit_dv), .fit_rdata(fit_rdata), .hold(hold),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .cmd_err(cmd_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard: each grant pushes the model word, each fit_dv pops and compares.
  always @(negedge clk) begin
    if (fit_gnt) begin
      exp_q.push_back(mem[fit_addr]);
      gcyc_q.push_back(cyc);
    end
    if (fit_dv) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fit_dv_unexpected: got fit_dv=1 data=%h, required no pending read", fit_rdata);
      end else begin
        logic [13:0] e;
        int g;
        e = exp_q.pop_front();
        g = gcyc_q.pop_front();
        if (fit_rdata !== e || cyc != g + 2) begin
          failures++;
          $display("FAIL fit_sb: got data=%h latency=%0d, required data=%h latency=2", fit_rdata, cyc - g, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [9:0] a, input logic [13:0] d);
    vme_bus_in  = {c, 8'b0, a, d};
    vme_wrpulse = 1'b1;
    tick();
    vme_wrpulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; fit_req = 1'b0; vme_wrpulse = 1'b0; vme_rdpulse = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic rd_ack();
    vme_rdpulse = 1'b1;
    tick();
    vme_rdpulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; fit_req = 1'b1; fit_addr = 10'd3;
    vme_wrpulse = 1'b0; vme_rdpulse = 1'b0; vme_bus_in = '0;
    bd_we = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bd_addr = i[9:0];
      bd_data = 14'(i * 3 + 7);
      tick();
    end
    bd_addr = 10'd5; bd_data = 14'h1A2B; tick();
    bd_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({fit_gnt, fit_dv, vme_dv, hold, ram_en, ram_we, cmd_err} !== 7'b0 || vme_rdata !== 34'b0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt/dv/vdv/hold/en/we/err=%b rdata=%h, required all 0",
               {fit_gnt, fit_dv, vme_dv, hold, ram_en, ram_we, cmd_err}, vme_rdata);
    end
    fit_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fit_read();
    int g;
    bit seen;
    fit_req = 1'b1; fit_addr = 10'd5;
    @(negedge clk);
    g = cyc;
    checks++;
    if (fit_gnt !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 10'd5) begin
      failures++;
      $display("FAIL fit_grant: got gnt=%b en=%b addr=%0d, required 1 1 5", fit_gnt, ram_en, ram_addr);
    end
    tick();
    fit_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (fit_dv) begin
        seen = 1'b1;
        checks++;
        if (fit_rdata !== 14'h1A2B || cyc - g != 2) begin
          failures++;
          $display("FAIL fit_read: got data=%h latency=%0d, required 1a2b latency 2", fit_rdata, cyc - g);
        end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL fit_read_timeout: got no fit_dv, required fit_dv within 2 cycles");
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      fit_req = 1'b1; fit_addr = 10'(10 + k);
      @(negedge clk);
      checks++;
      if (fit_gnt !== 1'b1 || ram_addr !== 10'(10 + k)) begin
        failures++;
        $display("FAIL b2b_grant%0d: got gnt=%b addr=%0d, required 1 %0d", k, fit_gnt, ram_addr, 10 + k);
      end
      tick();
    end
    fit_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got %0d outstanding reads, required 0", exp_q.size());
    end
  endtask

  task automatic test_load();
    send_cmd(2'b01, 10'd1022, 14'd0);
    @(negedge clk);
    checks++;
    if (hold !== 1'b0) begin
      failures++; $display("FAIL load_hold_pre: got hold=%b, required 0", hold);
    end
    send_cmd(2'b00, 10'd0, 14'd1);
    @(negedge clk);
    checks++;
    if (hold !== 1'b1) begin
      failures++; $display("FAIL load_hold_on: got hold=%b, required 1", hold);
    end
    send_cmd(2'b00, 10'd0, 14'd2);
    send_cmd(2'b00, 10'd0, 14'd3);
    send_cmd(2'b11, 10'd0, 14'd0);
    @(negedge clk);
    checks++;
    if (hold !== 1'b1) begin
      failures++; $display("FAIL load_hold_end: got hold=%b, required 1", hold);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hold !== 1'b0) begin
      failures++; $display("FAIL load_hold_off: got hold=%b, required 0", hold);
    end
    checks++;
    if (mem[1022] !== 14'd1 || mem[1023] !== 14'd2 || mem[0] !== 14'd3) begin
      failures++;
      $display("FAIL load_wrap: got ram[1022]=%0d ram[1023]=%0d ram[0]=%0d, required 1 2 3",
               mem[1022], mem[1023], mem[0]);
    end
    tick();
  endtask

  task automatic test_fit_hold();
    send_cmd(2'b01, 10'd50, 14'd0);
    tick();
    fit_req = 1'b1; fit_addr = 10'd5;
    send_cmd(2'b00, 10'd0, 14'h0AAA);
    @(negedge clk);
    checks++;
    if (fit_gnt !== 1'b0 || hold !== 1'b1) begin
      failures++; $display("FAIL hold_gnt_a: got gnt=%b hold=%b, required 0 1", fit_gnt, hold);
    end
    send_cmd(2'b00, 10'd0, 14'h0BBB);
    send_cmd(2'b11, 10'd0, 14'd0);
    @(negedge clk);
    checks++;
    if (fit_gnt !== 1'b0 || hold !== 1'b1) begin
      failures++; $display("FAIL hold_gnt_b: got gnt=%b hold=%b, required 0 1", fit_gnt, hold);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fit_gnt !== 1'b1 || hold !== 1'b0) begin
      failures++; $display("FAIL hold_resume: got gnt=%b hold=%b, required 1 0", fit_gnt, hold);
    end
    tick();
    fit_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (mem[50] !== 14'h0AAA || mem[51] !== 14'h0BBB) begin
      failures++;
      $display("FAIL hold_writes: got ram[50]=%h ram[51]=%h, required 0aaa 0bbb", mem[50], mem[51]);
    end
  endtask

  task automatic wait_vdv(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (vme_dv) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got vme_dv=0, required vme_dv=1", nm);
    end
  endtask

  task automatic test_readback();
    logic [33:0] e1, e2;
    e1 = {2'b10, 8'b0, 10'd1022, 14'd1};
    e2 = {2'b10, 8'b0, 10'd1023, 14'd2};
    send_cmd(2'b01, 10'd1022, 14'd0);
    send_cmd(2'b10, 10'd0, 14'd0);
    wait_vdv("rb1");
    checks++;
    if (vme_rdata !== e1) begin
      failures++; $display("FAIL rb1_data: got %h, required %h", vme_rdata, e1);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (vme_dv !== 1'b1 || vme_rdata !== e1) begin
      failures++; $display("FAIL rb1_stable: got dv=%b data=%h, required 1 %h", vme_dv, vme_rdata, e1);
    end
    rd_ack();
    @(negedge clk);
    checks++;
    if (vme_dv !== 1'b0) begin
      failures++; $display("FAIL rb1_clear: got vme_dv=%b, required 0", vme_dv);
    end
    send_cmd(2'b10, 10'd0, 14'd0);
    wait_vdv("rb2");
    checks++;
    if (vme_rdata !== e2) begin
      failures++; $display("FAIL rb2_data: got %h, required %h", vme_rdata, e2);
    end
    rd_ack();
    send_cmd(2'b11, 10'd0, 14'd0);
    repeat (2) tick();
    checks++;
    if (hold !== 1'b0 || cmd_err !== 1'b0) begin
      failures++; $display("FAIL rb_end: got hold=%b err=%b, required 0 0", hold, cmd_err);
    end
  endtask

  task automatic test_overflow();
    logic [13:0] old2;
    logic [33:0] e;
    old2 = mem[2];
    e = {2'b10, 8'b0, 10'd0, 14'd3};
    send_cmd(2'b01, 10'd0, 14'd0);
    send_cmd(2'b10, 10'd0, 14'd0);
    wait_vdv("ovf");
    checks++;
    if (vme_rdata !== e) begin
      failures++; $display("FAIL ovf_rb: got %h, required %h", vme_rdata, e);
    end
    send_cmd(2'b00, 10'd0, 14'h03AA);
    send_cmd(2'b00, 10'd0, 14'h0155);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || vme_dv !== 1'b1) begin
      failures++; $display("FAIL ovf_err: got err=%b dv=%b, required 1 1", cmd_err, vme_dv);
    end
    rd_ack();
    repeat (3) tick();
    checks++;
    if (mem[1] !== 14'h03AA || mem[2] !== old2) begin
      failures++;
      $display("FAIL ovf_write: got ram[1]=%h ram[2]=%h, required 03aa %h", mem[1], mem[2], old2);
    end
    send_cmd(2'b11, 10'd0, 14'd0);
    repeat (2) tick();
    checks++;
    if (cmd_err !== 1'b1 || hold !== 1'b0) begin
      failures++; $display("FAIL ovf_sticky: got err=%b hold=%b, required 1 0", cmd_err, hold);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin
      failures++; $display("FAIL rst_err_clear: got cmd_err=%b, required 0", cmd_err);
    end
    send_cmd(2'b01, 10'd100, 14'd0);
    send_cmd(2'b00, 10'd0, 14'h0111);
    send_cmd(2'b00, 10'd0, 14'h0222);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (hold !== 1'b0) begin
      failures++; $display("FAIL rst_mid_hold: got hold=%b, required 0", hold);
    end
    reset = 1'b1;
    checks++;
    if (mem[100] !== 14'h0111 || mem[101] !== 14'h0222) begin
      failures++;
      $display("FAIL rst_mid_keep: got ram[100]=%h ram[101]=%h, required 0111 0222", mem[100], mem[101]);
    end
    send_cmd(2'b00, 10'd0, 14'h0777);
    tick();
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || hold !== 1'b0 || mem[0] !== 14'd3) begin
      failures++;
      $display("FAIL rst_idle_write: got err=%b hold=%b ram[0]=%h, required 1 0 0003", cmd_err, hold, mem[0]);
    end
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; fit_addr = '0;
    test_reset();
    test_fit_read();
    test_back_to_back();
    test_load();
    test_fit_hold();
    test_readback();
    test_overflow();
    test_reset_mid_load();
    do_reset();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL final: got outstanding=%0d err=%b, required 0 0", exp_q.size(), cmd_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coeff_ram_arbiter.md
Name: coeff_ram_arbiter

Overview:
- Shares the single-port coefficient RAM of the gigafitter mezzanine between two requesters: the VME coefficient loader and the fit engine, which reads coefficients during track fitting.
- Decodes 34-bit VME command words into address-set, write, readback and end-of-load operations.
- Holds the fit engine off during a load session and returns readback data with a data-valid strobe.
- Sits between the VME interface logic and the coefficient RAM and fitter datapath inside top.

Parameters:
ADDR_W, 10, coefficient RAM address width (depth 2**ADDR_W)
DATA_W, 14, coefficient word width

Ports:
clk  in  1  system clock (40 MHz)
reset  in  1  synchronous, active-low reset
vme_bus_in  in  34  VME command word; [33:32] cmd (00 write, 01 set address, 10 readback, 11 end load), [ADDR_W-1+14:14] address for cmd 01, [13:0] data for cmd 00
vme_wrpulse  in  1  one-cycle strobe, command word valid
vme_rdpulse  in  1  one-cycle strobe, host has consumed readback word
vme_dv  out  1  readback word valid on vme_rdata
vme_rdata  out  34  readback word: {2'b10, address, data}, zero-padded
fit_req  in  1  fit engine requests a RAM read
fit_addr  in  ADDR_W  fit engine read address
fit_gnt  out  1  one-cycle grant, fit_addr sampled this cycle
fit_dv  out  1  fit_rdata valid, two cycles after the matching fit_gnt
fit_rdata  out  DATA_W  coefficient returned to the fit engine
hold  out  1  high while a load session is open, stalls the upstream FIFO and fitter
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, one-cycle latency after ram_en
cmd_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs go to 0; state goes to IDLE; address pointer goes to 0; pending register is cleared.
  - Reset mid-load aborts the session and drops hold on the next cycle.
  - A readback that was in flight is discarded.
- Command capture:
  - vme_wrpulse latches vme_bus_in into a one-deep pending register.
  - If a second pulse arrives while the register is still full, the second command is dropped and cmd_err is set.
- States: IDLE, LOAD, RDWAIT, RDHOLD.
- IDLE:
  - fit_req has priority. It gives fit_gnt=1, ram_en=1, ram_addr=fit_addr in the same cycle, then fit_dv=1 with fit_rdata=ram_rdata two cycles later. Back-to-back grants run at one per cycle.
  - A pending cmd 01 loads the pointer, sets hold=1 and moves to LOAD. It is serviced only in a cycle with no fit_req.
  - A pending cmd 00, 10 or 11 in IDLE is consumed, ignored and sets cmd_err.
- LOAD:
  - hold=1 and fit_gnt=0 throughout.
  - cmd 00: ram_en=ram_we=1, ram_addr=pointer, ram_wdata=data; the pointer increments and wraps from 2**ADDR_W-1 to 0.
  - cmd 01: reloads the pointer.
  - cmd 10: ram_en=1 at the pointer, then go to RDWAIT.
  - cmd 11: hold falls the next cycle, then go to IDLE.
  - Throughput is one command per cycle.
- RDWAIT:
  - Capture ram_rdata into vme_rdata and set vme_dv=1.
  - The pointer increments so that sequential readback works.
  - Go to RDHOLD.
- RDHOLD:
  - vme_dv and vme_rdata stay stable until vme_rdpulse, then clear vme_dv and return to LOAD.
  - Commands arriving meanwhile wait in the pending register, subject to the overflow rule.
- vme_rdpulse outside RDHOLD is ignored.
- A fit_req that coincides with the cycle cmd 01 is serviced wins. The load starts the next cycle, and fit_dv for that request is still delivered.
- ram_we is never high unless the state is LOAD.

Test Plan:
- Reset, then fit_req with fit_addr=5 and RAM pre-filled with 0x1A2B -> fit_gnt in cycle 0, fit_dv=1 with fit_rdata=0x1A2B in cycle 2.
- Load session: cmd 01 addr=1022, writes 0x0001, 0x0002, 0x0003, then cmd 11 -> RAM[1022]=1, RAM[1023]=2, RAM[0]=3 (wrap); hold=1 from the cycle after cmd 01 until the cycle after cmd 11.
- Readback: cmd 01 addr=1022, cmd 10 -> vme_dv=1 with vme_rdata={2'b10,1022,0x0001} held until vme_rdpulse; a second cmd 10 returns 0x0002.
- fit_req held high throughout a load session -> fit_gnt=0 for the whole session; grants resume the cycle after hold falls.
- Two vme_wrpulse while in RDHOLD -> the first is queued and executed after vme_rdpulse, the second is dropped, cmd_err=1 until reset.
- reset=0 asserted during LOAD after two writes -> hold=0 and state IDLE next cycle; the two RAM writes already made remain; a following cmd 00 sets cmd_err.
